// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                                     |
// | Desc     : Shared types and default widths for the data-memory arbiter.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int c_default_addr_w = 27;
    localparam int c_default_data_w = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_IO   = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arb_rr2                                                     |
// | Desc     : Combinational two-way round-robin pick between core and IO.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   i_req_core,
    input  logic   i_req_io,
    input  grant_t i_last_grant,
    output grant_t o_grant,
    output logic   o_valid
);

    // On a tie the requester that did not win last time is picked.
    always_comb begin
        o_valid = i_req_core | i_req_io;
        o_grant = GNT_CORE;
        if (i_req_core && i_req_io) begin
            o_grant = (i_last_grant == GNT_CORE) ? GNT_IO : GNT_CORE;
        end else if (i_req_io) begin
            o_grant = GNT_IO;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_arbiter                                                |
// | Desc     : Serialises core MEM-stage and IO loader accesses onto a single   |
// |            valid/ready data-memory port, one transaction at a time.        |
// |            Define MEM_ARB_TIMEOUT_EN to enable the stalled-access watchdog. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = c_default_addr_w,
    parameter int DATA_W  = c_default_data_w,
    parameter int TIMEOUT = 1023
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_core,
    input  logic              we_core,
    input  logic [31:0]       addr_core,
    input  logic [DATA_W-1:0] wdata_core,
    output logic [DATA_W-1:0] rdata_core,
    output logic              done_core,
    input  logic              req_io,
    input  logic              we_io,
    input  logic [31:0]       addr_io,
    input  logic [DATA_W-1:0] wdata_io,
    output logic [DATA_W-1:0] rdata_io,
    output logic              done_io,
    output logic              err,
    output logic              valid_mem,
    output logic              rw_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] din_mem,
    input  logic [DATA_W-1:0] dout_mem,
    input  logic              ready_mem
);

    state_t            r_state;
    grant_t            r_last_grant;
    grant_t            r_gnt;
    logic              r_valid;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_rdata_core;
    logic [DATA_W-1:0] r_rdata_io;
    logic              r_done_core;
    logic              r_done_io;
    logic              r_err;

    grant_t            w_gnt;
    logic              w_gnt_valid;
    logic              w_sel_io;
    logic [DATA_W-1:0] w_rd_capture;

    // Upper address bits are deliberately dropped at the memory side.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^{addr_core[31:ADDR_W], addr_io[31:ADDR_W]};

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    assign w_cnt_next = r_cnt + c_cnt_w'(1);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT == 0);
`endif

    mem_arb_rr2 u_rr2 (
        .i_req_core   (req_core),
        .i_req_io     (req_io),
        .i_last_grant (r_last_grant),
        .o_grant      (w_gnt),
        .o_valid      (w_gnt_valid)
    );

    assign w_sel_io     = (w_gnt == GNT_IO);
    // Writes return zero so rdata never shows stale memory contents.
    assign w_rd_capture = r_rw ? '0 : dout_mem;

    // Main scheduler: grant in IDLE, hold the access in BUSY, pulse done in DONE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_IO;
            r_gnt        <= GNT_CORE;
            r_valid      <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_rdata_core <= '0;
            r_rdata_io   <= '0;
            r_done_core  <= 1'b0;
            r_done_io    <= 1'b0;
            r_err        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            r_done_core <= 1'b0;
            r_done_io   <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_rw         <= w_sel_io ? we_io : we_core;
                        r_addr       <= w_sel_io ? addr_io[ADDR_W-1:0] : addr_core[ADDR_W-1:0];
                        r_din        <= w_sel_io ? wdata_io : wdata_core;
                        r_valid      <= 1'b1;
                        r_state      <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_cnt        <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (ready_mem) begin
                        r_valid <= 1'b0;
                        r_state <= DONE;
                        if (r_gnt == GNT_IO) begin
                            r_done_io  <= 1'b1;
                            r_rdata_io <= w_rd_capture;
                        end else begin
                            r_done_core  <= 1'b1;
                            r_rdata_core <= w_rd_capture;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (w_cnt_next >= c_cnt_w'(TIMEOUT)) begin
                        // Watchdog abort: the memory transaction is abandoned.
                        r_valid <= 1'b0;
                        r_state <= DONE;
                        r_err   <= 1'b1;
                        if (r_gnt == GNT_IO) begin
                            r_done_io  <= 1'b1;
                            r_rdata_io <= '0;
                        end else begin
                            r_done_core  <= 1'b1;
                            r_rdata_core <= '0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_mem  = r_valid;
    assign rw_mem     = r_rw;
    assign addr_mem   = r_addr;
    assign din_mem    = r_din;
    assign rdata_core = r_rdata_core;
    assign rdata_io   = r_rdata_io;
    assign done_core  = r_done_core;
    assign done_io    = r_done_io;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_arbiter                                             |
// | Desc     : Self-checking bench for data_mem_arbiter with a behavioural     |
// |            arbitration/transaction model. Honours MEM_ARB_TIMEOUT_EN.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_data_mem_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 1023;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              req_core = 1'b0, we_core = 1'b0;
    logic [31:0]       addr_core = '0;
    logic [DATA_W-1:0] wdata_core = '0;
    logic [DATA_W-1:0] rdata_core;
    logic              done_core;
    logic              req_io = 1'b0, we_io = 1'b0;
    logic [31:0]       addr_io = '0;
    logic [DATA_W-1:0] wdata_io = '0;
    logic [DATA_W-1:0] rdata_io;
    logic              done_io;
    logic              err;
    logic              valid_mem;
    logic              rw_mem;
    logic [ADDR_W-1:0] addr_mem;
    logic [DATA_W-1:0] din_mem;
    logic [DATA_W-1:0] dout_mem = '0;
    logic              ready_mem = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit                m_last_io;
    bit                p_core, p_io;
    logic [DATA_W-1:0] m_rdata_core, m_rdata_io;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .req_core(req_core), .we_core(we_core), .addr_core(addr_core),
        .wdata_core(wdata_core), .rdata_core(rdata_core), .done_core(done_core),
        .req_io(req_io), .we_io(we_io), .addr_io(addr_io),
        .wdata_io(wdata_io), .rdata_io(rdata_io), .done_io(done_io),
        .err(err), .valid_mem(valid_mem), .rw_mem(rw_mem), .addr_mem(addr_mem),
        .din_mem(din_mem), .dout_mem(dout_mem), .ready_mem(ready_mem)
    );

    task automatic model_reset();
        m_last_io    = 1'b1;
        m_rdata_core = '0;
        m_rdata_io   = '0;
        p_core       = 1'b0;
        p_io         = 1'b0;
    endtask

    task automatic raise_core(input logic we, input logic [31:0] a, input logic [DATA_W-1:0] d);
        req_core = 1'b1; we_core = we; addr_core = a; wdata_core = d; p_core = 1'b1;
    endtask

    task automatic raise_io(input logic we, input logic [31:0] a, input logic [DATA_W-1:0] d);
        req_io = 1'b1; we_io = we; addr_io = a; wdata_io = d; p_io = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req_core = 1'b0; req_io = 1'b0; ready_mem = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // One full transaction starting from an IDLE-cycle negedge with >=1 request pending.
    task automatic txn(input int lat, input logic [DATA_W-1:0] rd, output bit got_io);
        bit                win_io;
        logic              we;
        logic [31:0]       a;
        logic [DATA_W-1:0] d, expd;
        win_io    = (p_core && p_io) ? !m_last_io : p_io;
        m_last_io = win_io;
        we = win_io ? we_io : we_core;
        a  = win_io ? addr_io : addr_core;
        d  = win_io ? wdata_io : wdata_core;
        @(negedge clk);
        checks++;
        if (valid_mem !== 1'b1 || rw_mem !== we || addr_mem !== a[ADDR_W-1:0] || din_mem !== d) begin
            errors++;
            $display("FAIL grant_fields: valid=%0b rw=%0b addr=%h din=%h, expected valid=1 rw=%0b addr=%h din=%h",
                     valid_mem, rw_mem, addr_mem, din_mem, we, a[ADDR_W-1:0], d);
        end
        for (int i = 0; i < lat; i++) begin
            ready_mem = 1'b0;
            dout_mem  = $urandom;
            @(negedge clk);
            checks++;
            if (valid_mem !== 1'b1 || rw_mem !== we || addr_mem !== a[ADDR_W-1:0] || din_mem !== d ||
                done_core !== 1'b0 || done_io !== 1'b0) begin
                errors++;
                $display("FAIL busy_hold: cycle=%0d valid=%0b rw=%0b addr=%h din=%h done=%0b%0b, expected 1 %0b %h %h 00",
                         i, valid_mem, rw_mem, addr_mem, din_mem, done_core, done_io, we, a[ADDR_W-1:0], d);
            end
        end
        ready_mem = 1'b1;
        dout_mem  = rd;
        @(negedge clk);
        ready_mem = 1'b0;
        dout_mem  = $urandom;
        expd = we ? '0 : rd;
        if (win_io) m_rdata_io = expd; else m_rdata_core = expd;
        got_io = done_io;
        checks++;
        if (done_core !== !win_io || done_io !== win_io || err !== 1'b0 || valid_mem !== 1'b0 ||
            rdata_core !== m_rdata_core || rdata_io !== m_rdata_io) begin
            errors++;
            $display("FAIL done_cycle: done=%0b%0b err=%0b valid=%0b rd_core=%h rd_io=%h, expected done=%0b%0b err=0 valid=0 rd_core=%h rd_io=%h",
                     done_core, done_io, err, valid_mem, rdata_core, rdata_io, !win_io, win_io, m_rdata_core, m_rdata_io);
        end
        if (win_io) begin req_io = 1'b0; p_io = 1'b0; end
        else begin req_core = 1'b0; p_core = 1'b0; end
        @(negedge clk);
        checks++;
        if (done_core !== 1'b0 || done_io !== 1'b0 || valid_mem !== 1'b0 ||
            rdata_core !== m_rdata_core || rdata_io !== m_rdata_io) begin
            errors++;
            $display("FAIL done_pulse_end: done=%0b%0b valid=%0b rd_core=%h rd_io=%h, expected 00 0 %h %h",
                     done_core, done_io, valid_mem, rdata_core, rdata_io, m_rdata_core, m_rdata_io);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ready_mem = 1'b1;
        dout_mem  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_mem, rw_mem, done_core, done_io, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 00000", {valid_mem, rw_mem, done_core, done_io, err});
        end
        checks++;
        if (addr_mem !== '0 || din_mem !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h din=%h, expected 0 0", addr_mem, din_mem);
        end
        checks++;
        if (rdata_core !== '0 || rdata_io !== '0) begin
            errors++;
            $display("FAIL reset_rdata: core=%h io=%h, expected 0 0", rdata_core, rdata_io);
        end
        ready_mem = 1'b0;
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (valid_mem !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_ignored: valid=%0b, expected 0", valid_mem);
        end
    endtask

    task automatic test_core_read();
        bit g;
        raise_core(1'b0, 32'h0000_0040, 32'h1111_2222);
        txn(0, 32'hDEAD_BEEF, g);
        checks++;
        if (rdata_core !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL core_read_data: got %h, expected deadbeef", rdata_core);
        end
    endtask

    task automatic test_io_write_stall();
        bit g;
        raise_io(1'b1, 32'h0000_4000, 32'h1234_5678);
        txn(15, $urandom, g);
        checks++;
        if (g !== 1'b1 || rdata_io !== '0) begin
            errors++;
            $display("FAIL io_write: done_io=%0b rdata_io=%h, expected 1 0", g, rdata_io);
        end
    endtask

    task automatic test_back_to_back();
        bit g;
        do_reset();
        raise_core($urandom, $urandom, $urandom);
        raise_io($urandom, $urandom, $urandom);
        for (int k = 0; k < 8; k++) begin
            txn(0, $urandom, g);
            checks++;
            if (g !== k[0]) begin
                errors++;
                $display("FAIL b2b_order: txn=%0d got_io=%0b, expected %0b", k, g, k[0]);
            end
            if (k < 7) begin
                if (g) raise_io($urandom, $urandom, $urandom);
                else   raise_core($urandom, $urandom, $urandom);
            end
        end
        req_core = 1'b0; req_io = 1'b0; p_core = 1'b0; p_io = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        bit g;
        raise_core(1'b0, $urandom, $urandom);
        @(negedge clk);
        checks++;
        if (valid_mem !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy: valid=%0b, expected 1", valid_mem);
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_mem, rw_mem, done_core, done_io, err} !== 5'b0 || addr_mem !== '0 || din_mem !== '0 ||
            rdata_core !== '0 || rdata_io !== '0) begin
            errors++;
            $display("FAIL midop_reset: ctrl=%b addr=%h din=%h rd=%h/%h, expected all 0",
                     {valid_mem, rw_mem, done_core, done_io, err}, addr_mem, din_mem, rdata_core, rdata_io);
        end
        req_core = 1'b0;
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if ({valid_mem, done_core, done_io} !== 3'b0) begin
            errors++;
            $display("FAIL midop_no_done: got %b, expected 000", {valid_mem, done_core, done_io});
        end
        raise_io(1'b0, $urandom, $urandom);
        txn(2, $urandom, g);
    endtask

    task automatic test_random();
        bit g;
        for (int t = 0; t < 40; t++) begin
            if (!p_core && !p_io) begin
                for (int j = 0, n = $urandom_range(0, 2); j < n; j++) begin
                    ready_mem = $urandom;
                    @(negedge clk);
                    checks++;
                    if ({valid_mem, done_core, done_io} !== 3'b0) begin
                        errors++;
                        $display("FAIL idle_quiet: got %b, expected 000", {valid_mem, done_core, done_io});
                    end
                end
            end
            if (!p_core && ($urandom % 2)) raise_core($urandom, $urandom, $urandom);
            if (!p_io && ($urandom % 2)) raise_io($urandom, $urandom, $urandom);
            if (!p_core && !p_io) begin
                if ($urandom % 2) raise_io($urandom, $urandom, $urandom);
                else raise_core($urandom, $urandom, $urandom);
            end
            txn($urandom_range(0, 4), $urandom, g);
        end
        req_core = 1'b0; req_io = 1'b0; p_core = 1'b0; p_io = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit g;
        int cnt;
        raise_core(1'b0, $urandom, $urandom);
        txn(0, 32'hA5A5_0001, g);
        raise_core(1'b0, $urandom, $urandom);
        txn(TIMEOUT - 1, 32'h0BAD_F00D, g);
        raise_core(1'b0, $urandom, $urandom);
        m_last_io = 1'b0;
        @(negedge clk);
        cnt = 0;
        while (valid_mem === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== TIMEOUT || done_core !== 1'b1 || err !== 1'b1 || rdata_core !== '0 || done_io !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: busy=%0d done=%0b%0b err=%0b rd=%h, expected %0d 10 1 0",
                     cnt, done_core, done_io, err, rdata_core, TIMEOUT);
        end
        req_core = 1'b0; p_core = 1'b0;
        @(negedge clk);
        checks++;
        if ({err, done_core, valid_mem} !== 3'b0) begin
            errors++;
            $display("FAIL timeout_pulse_end: got %b, expected 000", {err, done_core, valid_mem});
        end
    endtask
`else
    task automatic test_long_stall();
        bit g;
        raise_core(1'b0, $urandom, $urandom);
        txn(1999, 32'hCAFE_0123, g);
        checks++;
        if (rdata_core !== 32'hCAFE_0123 || g !== 1'b0) begin
            errors++;
            $display("FAIL long_stall: rd=%h got_io=%0b, expected cafe0123 0", rdata_core, g);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_core_read();
        test_io_write_stall();
        test_back_to_back();
        test_reset_midop();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
